vga_fb_reader: RTL and testbench
================================

VGA_FB_READER -- requirements
Module: vga_fb_reader

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48: horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33: vertical porch and sync widths in lines.
REQ-005 SHALL have port i_clk, input, 1: pixel clock; all logic runs on its rising edge only.
REQ-006 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port i_en, input, 1: display enable, sampled only at frame boundary.
REQ-008 SHALL have port o_rd_addr, output, 19: frame-buffer read address, row-major, 0..H_ACTIVE*V_ACTIVE-1.
REQ-009 SHALL have port i_rd_data, input, 12: frame-buffer pixel RGB444, valid exactly 1 clock after o_rd_addr.
REQ-010 SHALL have port o_rgb, output, 12: pixel to DAC; 0 outside active video.
REQ-011 SHALL have ports o_hsync and o_vsync, output, 1 each: syncs, active-low.
REQ-012 SHALL have port o_frame_start, output, 1: single-clock pulse at first active pixel of each displayed frame.

Function
REQ-013 SHALL keep counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1), H_TOTAL = sum of horizontal parameters (800), V_TOTAL = sum of vertical parameters (525).
REQ-014 SHALL increment h every clock; at H_TOTAL-1, h wraps to 0 and v increments; at v = V_TOTAL-1 with h wrap, v wraps to 0.
REQ-015 SHALL define active = (h < H_ACTIVE) and (v < V_ACTIVE) and running.
REQ-016 SHALL assert hsync (pre-delay) for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], and vsync for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
REQ-017 SHALL generate o_rd_addr incrementally, with no multiplier: +1 per active clock, reset to 0 when h = 0 and v = 0.
REQ-018 SHALL register o_rd_addr at stage 1, so address for counter value (h,v) at cycle t is on o_rd_addr at t+1.
REQ-019 SHALL register i_rd_data into o_rgb at cycle t+3 for counter value (h,v) at t, and delay hsync, vsync, and active by the same 3 stages; all three outputs are mutually aligned.
REQ-020 SHALL force o_rgb to 0 whenever the delayed active is 0.
REQ-021 SHALL implement states IDLE and RUN; running = (state == RUN).
REQ-022 SHALL, in IDLE, keep counters free-running and syncs generated (monitor stays locked), o_rgb = 0, o_rd_addr held at 0.
REQ-023 SHALL sample i_en only on the clock where h = H_TOTAL-1 and v = V_TOTAL-1: 1 -> RUN, 0 -> IDLE for the next frame.
REQ-024 SHALL ignore i_en changes mid-frame; a frame in progress always completes in its current state.
REQ-025 SHALL pulse o_frame_start for one clock, aligned with o_rgb of pixel (0,0), only in RUN frames.
REQ-026 SHALL not wrap o_rd_addr within a frame; the last active pixel reads address H_ACTIVE*V_ACTIVE-1 (307199).

Reset
REQ-027 SHALL, while i_rst = 1, force h = 0, v = 0, state = IDLE, all pipeline stages cleared, o_rd_addr = 0, o_rgb = 0, o_hsync = 1, o_vsync = 1, o_frame_start = 0.
REQ-028 SHALL apply reset identically when asserted mid-frame, with counting restarting at (0,0) on the first clock after release.

Verification
REQ-029 SHALL test: i_rst released, i_en = 1 -> first frame is IDLE (o_rgb = 0), second frame o_frame_start pulses exactly 3 clocks after h=0,v=0.
REQ-030 SHALL test: model BRAM returning data = addr[11:0] with 1-clock latency -> o_rgb at pixel (5,2) equals 1285[11:0] = 0x505.
REQ-031 SHALL test: count clocks -> o_hsync low 96 clocks per 800, o_vsync low 2 lines per 525, o_rgb = 0 throughout blanking.
REQ-032 SHALL test: i_en deasserted at line 100 of a RUN frame -> frame completes through address 307199, next frame o_rgb = 0 and no o_frame_start.
REQ-033 SHALL test: i_rst pulsed at h=300, v=200 -> outputs reach reset values the next clock, hsync restarts at correct offset 656 clocks after release (+3 pipeline).

Source files
------------

// File: rtl/vga_fb_reader.sv
// rtl/vga_fb_reader.sv - VGA timing generator that streams a row-major frame buffer to the DAC.
// Three-stage pipeline: address register, one-clock buffer read, output register with syncs aligned.
module vga_fb_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    output logic [18:0] o_rd_addr,
    input  logic [11:0] i_rd_data,
    output logic [11:0] o_rgb,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_frame_start
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC - 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [18:0]   rd_addr_q, rd_addr_d;
    logic          act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d, fs1_q, fs1_d;
    logic          act2_q, act2_d, hs2_q, hs2_d, vs2_q, vs2_d, fs2_q, fs2_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, frame_start_q, frame_start_d;

    logic line_end, frame_end, origin, running, active0, hs0, vs0;

    always_comb begin
        line_end  = (h_q == HW'(H_TOTAL - 1));
        frame_end = line_end && (v_q == VW'(V_TOTAL - 1));
        origin    = (h_q == '0) && (v_q == '0);
        running   = (state_q == RUN);
        active0   = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE)) && running;
        hs0       = (h_q >= HW'(HS_START)) && (h_q <= HW'(HS_END));
        vs0       = (v_q >= VW'(VS_START)) && (v_q <= VW'(VS_END));

        h_d = line_end ? '0 : h_q + HW'(1);
        v_d = v_q;
        if (line_end) begin
            v_d = frame_end ? '0 : v_q + VW'(1);
        end

        // i_en only takes effect for the frame that starts on the next clock
        state_d = state_q;
        if (frame_end) begin
            state_d = i_en ? RUN : IDLE;
        end

        // Address advances on each active pixel; the origin restarts it so it never wraps mid-frame
        if (origin || !running) begin
            rd_addr_d = '0;
        end else if (active0) begin
            rd_addr_d = rd_addr_q + 19'd1;
        end else begin
            rd_addr_d = rd_addr_q;
        end

        act1_d = active0;
        hs1_d  = hs0;
        vs1_d  = vs0;
        fs1_d  = active0 && origin;

        act2_d = act1_q;
        hs2_d  = hs1_q;
        vs2_d  = vs1_q;
        fs2_d  = fs1_q;

        rgb_d         = act2_q ? i_rd_data : 12'd0;
        hsync_d       = ~hs2_q;
        vsync_d       = ~vs2_q;
        frame_start_d = fs2_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            h_q           <= '0;
            v_q           <= '0;
            rd_addr_q     <= '0;
            act1_q        <= 1'b0;
            hs1_q         <= 1'b0;
            vs1_q         <= 1'b0;
            fs1_q         <= 1'b0;
            act2_q        <= 1'b0;
            hs2_q         <= 1'b0;
            vs2_q         <= 1'b0;
            fs2_q         <= 1'b0;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            rd_addr_q     <= rd_addr_d;
            act1_q        <= act1_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            fs1_q         <= fs1_d;
            act2_q        <= act2_d;
            hs2_q         <= hs2_d;
            vs2_q         <= vs2_d;
            fs2_q         <= fs2_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_rd_addr     = rd_addr_q;
    assign o_rgb         = rgb_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_fb_reader.sv
// tb/tb_vga_fb_reader.sv - randomized bench for vga_fb_reader against a frame-position reference model.
module tb_vga_fb_reader;
    localparam int HA = 16, HFP = 4, HS = 6, HBP = 4;
    localparam int VA = 8, VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int NPIX = HA * VA;
    localparam int MAXF = 256;

    logic        clk = 1'b0;
    logic        i_rst, i_en;
    logic [18:0] o_rd_addr;
    logic [11:0] i_rd_data, o_rgb;
    logic        o_hsync, o_vsync, o_frame_start;

    always #5 clk = ~clk;

    vga_fb_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .o_rd_addr(o_rd_addr),
        .i_rd_data(i_rd_data), .o_rgb(o_rgb), .o_hsync(o_hsync),
        .o_vsync(o_vsync), .o_frame_start(o_frame_start)
    );

    // Frame buffer whose content equals its own address, one clock of read latency
    always @(posedge clk) i_rd_data <= o_rd_addr[11:0];

    int errors = 0;
    int checks = 0;
    int c = 0;
    bit armed = 1'b0;
    bit run_frame [MAXF];
    int hs_low = 0, vs_low = 0, fs_seen = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, c);
        end
    endtask

    function automatic bit frame_runs(input int k);
        int f;
        f = k / FRAME;
        return (f < MAXF) ? run_frame[f] : 1'b0;
    endfunction

    function automatic bit is_active(input int k);
        return ((k % HT) < HA) && (((k / HT) % VT) < VA) && frame_runs(k);
    endfunction

    task automatic check_outputs();
        int k, h, v;
        bit act;
        if (c >= 1) begin
            k = c - 1;
            h = k % HT;
            v = (k / HT) % VT;
            if (!frame_runs(k))
                check_val("addr_idle", 32'(o_rd_addr), 32'd0);
            else if (is_active(k))
                check_val((h == HA - 1 && v == VA - 1) ? "last_addr" : "addr",
                          32'(o_rd_addr), 32'(v * HA + h));
        end else begin
            check_val("addr_rst", 32'(o_rd_addr), 32'd0);
        end
        if (c >= 3) begin
            k = c - 3;
            h = k % HT;
            v = (k / HT) % VT;
            act = is_active(k);
            check_val(act ? "rgb_active" : "rgb_blank", 32'(o_rgb),
                      act ? 32'((v * HA + h) % 4096) : 32'd0);
            if (act && h == 5 && v == 2)
                check_val("px_5_2", 32'(o_rgb), 32'(2 * HA + 5));
            check_val("hsync", 32'(o_hsync), 32'(!(h >= HA + HFP && h < HA + HFP + HS)));
            check_val("vsync", 32'(o_vsync), 32'(!(v >= VA + VFP && v < VA + VFP + VS)));
            check_val("frame_start", 32'(o_frame_start), 32'(frame_runs(k) && h == 0 && v == 0));
            hs_low += int'(!o_hsync);
            vs_low += int'(!o_vsync);
            fs_seen += int'(o_frame_start);
            if (k % FRAME == FRAME - 1) begin
                check_val("hsync_low_clocks", 32'(hs_low), 32'(HS * VT));
                check_val("vsync_low_clocks", 32'(vs_low), 32'(VS * HT));
                hs_low = 0;
                vs_low = 0;
            end
        end else begin
            check_val("rgb_rst", 32'(o_rgb), 32'd0);
            check_val("hsync_rst", 32'(o_hsync), 32'd1);
            check_val("vsync_rst", 32'(o_vsync), 32'd1);
            check_val("frame_start_rst", 32'(o_frame_start), 32'd0);
            hs_low = 0;
            vs_low = 0;
        end
    endtask

    // One clock: the model records what the coming edge samples, then outputs are checked mid-cycle
    task automatic tick();
        if (i_rst) begin
            for (int i = 0; i < MAXF; i++) run_frame[i] = 1'b0;
        end else if (c % FRAME == FRAME - 1 && c / FRAME + 1 < MAXF) begin
            run_frame[c / FRAME + 1] = i_en;
        end
        @(posedge clk);
        c = i_rst ? 0 : c + 1;
        if (i_rst) armed = 1'b1;
        @(negedge clk);
        if (armed) check_outputs();
    endtask

    initial begin
        int n;
        i_rst = 1'b1;
        i_en  = 1'b1;
        for (int i = 0; i < MAXF; i++) run_frame[i] = 1'b0;
        repeat (4) tick();
        i_rst = 1'b0;
        repeat (3 * FRAME) tick();

        // Enable dropped partway through a running frame
        repeat (4 * HT) tick();
        i_en = 1'b0;
        repeat (2 * FRAME) tick();
        i_en = 1'b1;
        repeat (2 * FRAME) tick();

        // Reset pulsed mid-frame at h=20, v=5
        n = (5 * HT + 20 - (c % FRAME) + FRAME) % FRAME;
        repeat (n) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        repeat (3 * FRAME) tick();

        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 149) == 0) i_en = ~i_en;
            if ($urandom_range(0, 3999) == 0) begin
                i_rst = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
                i_rst = 1'b0;
            end
            tick();
        end

        check_val("frame_starts_seen", 32'(fs_seen > 0), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
